// File: rtl/ddr3_dfi_emu.sv
// DFI-side stand-in for a DDR3 PHY plus device. It decodes DFI commands, tracks open
// rows per bank, keeps write data in on-chip RAM and replays read bursts at a fixed latency.
module ddr3_dfi_emu #(
    parameter int DDR_ROW_BITS  = 15,
    parameter int DDR_COL_BITS  = 10,
    parameter int DFI_DQ_WIDTH  = 32,
    parameter int DFI_DM_WIDTH  = 4,
    parameter int PHY_BURSTLEN  = 4,
    parameter int RD_LATENCY    = 3,
    parameter int MEM_ADDR_BITS = 10
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    dfi_rst_ni,
    input  logic                    dfi_cke_i,
    input  logic                    dfi_cs_ni,
    input  logic                    dfi_ras_ni,
    input  logic                    dfi_cas_ni,
    input  logic                    dfi_we_ni,
    input  logic                    dfi_odt_i,
    input  logic [2:0]              dfi_bank_i,
    input  logic [DDR_ROW_BITS-1:0] dfi_addr_i,
    input  logic                    dfi_wstb_i,
    input  logic                    dfi_wren_i,
    input  logic [DFI_DM_WIDTH-1:0] dfi_mask_i,
    input  logic [DFI_DQ_WIDTH-1:0] dfi_data_i,
    input  logic                    dfi_rden_i,
    output logic                    dfi_rvld_o,
    output logic                    dfi_last_o,
    output logic [DFI_DQ_WIDTH-1:0] dfi_data_o,
    output logic                    emu_err_o,
    output logic [2:0]              emu_ecode_o
);
    localparam int BL_LOG  = $clog2(PHY_BURSTLEN);
    localparam int COL_LSB = BL_LOG + 1;
    localparam int HI_W    = MEM_ADDR_BITS - BL_LOG;
    localparam int FULL_W  = DDR_ROW_BITS + 3 + DDR_COL_BITS - COL_LSB;
    localparam int BURST_W = PHY_BURSTLEN * DFI_DQ_WIDTH;
    localparam logic [BL_LOG-1:0] LAST_BEAT = BL_LOG'(PHY_BURSTLEN - 1);

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_NOP = 3'b111
    } cmd_e;

    cmd_e cmd;
    logic cmd_en, is_act, is_pre, is_ref, is_rd, is_wr;

    assign cmd    = cmd_e'({dfi_ras_ni, dfi_cas_ni, dfi_we_ni});
    assign cmd_en = dfi_rst_ni && dfi_cke_i && !dfi_cs_ni;
    assign is_act = cmd_en && (cmd == CMD_ACT);
    assign is_pre = cmd_en && (cmd == CMD_PRE);
    assign is_ref = cmd_en && (cmd == CMD_REF);
    assign is_rd  = cmd_en && (cmd == CMD_RD);
    assign is_wr  = cmd_en && (cmd == CMD_WR);

    // Bank tracking
    logic [7:0]              open_q, open_d;
    logic [DDR_ROW_BITS-1:0] row_q [8];

    always_comb begin
        open_d = open_q;
        if (is_act) open_d[dfi_bank_i] = 1'b1;
        if (is_pre) begin
            if (dfi_addr_i[10]) open_d = '0;
            else                open_d[dfi_bank_i] = 1'b0;
        end
        if (!dfi_rst_ni) open_d = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            open_q <= '0;
            for (int i = 0; i < 8; i++) row_q[i] <= '0;
        end else begin
            open_q <= open_d;
            if (is_act) row_q[dfi_bank_i] <= dfi_addr_i;
        end
    end

    // Only the burst-aligned upper part of the word address is kept; the beat fills the low bits.
    logic [FULL_W-1:0] full_addr;
    logic [HI_W-1:0]   cmd_hi;

    assign full_addr = {row_q[dfi_bank_i], dfi_bank_i, dfi_addr_i[DDR_COL_BITS-1:COL_LSB]};
    assign cmd_hi    = full_addr[HI_W-1:0];

    // Write path
    logic                     wr_pend_q, wr_pend_d;
    logic [HI_W-1:0]          wr_hi_q, wr_hi_d;
    logic [BL_LOG-1:0]        wr_beat_q, wr_beat_d;
    logic                     wr_fire, wr_final;
    logic [MEM_ADDR_BITS-1:0] wr_addr;
    logic [DFI_DQ_WIDTH-1:0]  mem_q [2**MEM_ADDR_BITS];

    assign wr_fire  = dfi_rst_ni && dfi_wren_i && wr_pend_q;
    assign wr_final = wr_fire && (wr_beat_q == LAST_BEAT);
    assign wr_addr  = {wr_hi_q, wr_beat_q};

    always_comb begin
        wr_pend_d = wr_pend_q;
        wr_hi_d   = wr_hi_q;
        wr_beat_d = wr_beat_q;
        if (wr_fire) begin
            wr_beat_d = wr_beat_q + 1'b1;
            if (wr_final) wr_pend_d = 1'b0;
        end
        if (is_wr) begin
            wr_pend_d = 1'b1;
            wr_hi_d   = cmd_hi;
            wr_beat_d = '0;
        end
        if (!dfi_rst_ni) begin
            wr_pend_d = 1'b0;
            wr_beat_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_pend_q <= 1'b0;
            wr_hi_q   <= '0;
            wr_beat_q <= '0;
        end else begin
            wr_pend_q <= wr_pend_d;
            wr_hi_q   <= wr_hi_d;
            wr_beat_q <= wr_beat_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            for (int i = 0; i < DFI_DM_WIDTH; i++)
                if (!dfi_mask_i[i]) mem_q[wr_addr][i*8 +: 8] <= dfi_data_i[i*8 +: 8];
        end
    end

    // The whole burst is captured on the RD cycle, so a same-cycle write beat is not seen.
    logic [BURST_W-1:0] rd_snap;

    always_comb begin
        rd_snap = '0;
        for (int b = 0; b < PHY_BURSTLEN; b++)
            rd_snap[b*DFI_DQ_WIDTH +: DFI_DQ_WIDTH] = mem_q[{cmd_hi, BL_LOG'(b)}];
    end

    logic               em_v;
    logic [BURST_W-1:0] em_data;

    if (RD_LATENCY == 1) begin : g_lat1
        assign em_v    = is_rd;
        assign em_data = rd_snap;
    end else begin : g_pipe
        logic [RD_LATENCY-2:0] pv_q;
        logic [BURST_W-1:0]    pd_q [RD_LATENCY-1];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                pv_q <= '0;
            end else if (!dfi_rst_ni) begin
                pv_q <= '0;
            end else begin
                pv_q[0] <= is_rd;
                for (int i = 1; i < RD_LATENCY - 1; i++) pv_q[i] <= pv_q[i-1];
            end
        end

        always_ff @(posedge clock) begin
            pd_q[0] <= rd_snap;
            for (int i = 1; i < RD_LATENCY - 1; i++) pd_q[i] <= pd_q[i-1];
        end

        assign em_v    = pv_q[RD_LATENCY-2];
        assign em_data = pd_q[RD_LATENCY-2];
    end

    // Read output stage
    logic                    out_act_q, out_act_d;
    logic [BL_LOG-1:0]       out_beat_q, out_beat_d;
    logic [BURST_W-1:0]      out_buf_q, out_buf_d;
    logic                    rvld_q, rvld_d, last_q, last_d;
    logic [DFI_DQ_WIDTH-1:0] data_q, data_d;

    always_comb begin
        out_act_d  = out_act_q;
        out_beat_d = out_beat_q;
        out_buf_d  = out_buf_q;
        rvld_d     = 1'b0;
        last_d     = 1'b0;
        data_d     = '0;
        if (em_v) begin
            out_buf_d  = em_data;
            data_d     = em_data[DFI_DQ_WIDTH-1:0];
            rvld_d     = 1'b1;
            last_d     = (PHY_BURSTLEN == 1);
            out_beat_d = BL_LOG'(1);
            out_act_d  = (PHY_BURSTLEN > 1);
        end else if (out_act_q) begin
            data_d     = out_buf_q[out_beat_q*DFI_DQ_WIDTH +: DFI_DQ_WIDTH];
            rvld_d     = 1'b1;
            last_d     = (out_beat_q == LAST_BEAT);
            out_beat_d = out_beat_q + 1'b1;
            out_act_d  = (out_beat_q != LAST_BEAT);
        end
        if (!dfi_rst_ni) begin
            out_act_d = 1'b0;
            rvld_d    = 1'b0;
            last_d    = 1'b0;
            data_d    = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_act_q  <= 1'b0;
            out_beat_q <= '0;
            rvld_q     <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            out_act_q  <= out_act_d;
            out_beat_q <= out_beat_d;
            rvld_q     <= rvld_d;
            last_q     <= last_d;
            data_q     <= data_d;
        end
    end

    always_ff @(posedge clock) begin
        out_buf_q <= out_buf_d;
    end

    // Lowest code wins when several violations land on the same cycle.
    logic [2:0] viol_code;
    logic       err_q;
    logic [2:0] ecode_q;

    always_comb begin
        viol_code = 3'd0;
        if (em_v && out_act_q)                          viol_code = 3'd6;
        if (dfi_rst_ni && dfi_wren_i && !wr_pend_q)     viol_code = 3'd5;
        if (is_wr && wr_pend_q && !wr_final)            viol_code = 3'd4;
        if ((is_rd || is_wr) && !open_q[dfi_bank_i])    viol_code = 3'd3;
        if (is_ref && (|open_q))                        viol_code = 3'd2;
        if (is_act && open_q[dfi_bank_i])               viol_code = 3'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q   <= 1'b0;
            ecode_q <= 3'd0;
        end else if (!err_q && (viol_code != 3'd0)) begin
            err_q   <= 1'b1;
            ecode_q <= viol_code;
        end
    end

    assign dfi_rvld_o  = rvld_q;
    assign dfi_last_o  = last_q;
    assign dfi_data_o  = data_q;
    assign emu_err_o   = err_q;
    assign emu_ecode_o = ecode_q;

    logic unused_ok;
    assign unused_ok = ^{dfi_odt_i, dfi_wstb_i, dfi_rden_i, full_addr[FULL_W-1:HI_W]};

endmodule
